// File: rtl/mac_sequencer.sv
`default_nettype none
// ============================================================================
// mac_sequencer: time-shares one external multiply-add unit for trinomials
// ((a*x+b)*x+c) and sums of products (sum of a*x).  Revision 1.0
// ============================================================================
module mac_sequencer #(
  parameter int DW        = 8,
  parameter int OW        = 17,
  parameter int MAC_LAT   = 1,
  parameter int MAX_TERMS = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          mode,
  input  logic          valid_input,
  input  logic          last_input,
  input  logic [DW-1:0] num_a,
  input  logic [DW-1:0] num_b,
  input  logic [DW-1:0] num_c,
  input  logic [DW-1:0] num_x,
  output logic          ready,
  output logic          mac_start,
  output logic [OW-1:0] mac_in_1,
  output logic [DW-1:0] mac_in_2,
  output logic [OW-1:0] mac_in_add,
  input  logic [OW-1:0] mac_out,
  output logic          valid_output,
  output logic [OW-1:0] final_output,
  output logic          forced_last
);

  localparam int            CW        = $clog2(MAX_TERMS + 1);
  localparam int            WW        = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  localparam logic [CW-1:0] MAX_CNT   = CW'(MAX_TERMS);
  localparam logic [WW-1:0] WAIT_INIT = WW'(MAC_LAT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    OUT   = 2'd3
  } state_t;

  state_t        state;
  logic [DW-1:0] c_q;
  logic          last_q;
  logic          mode_q;
  logic          pass2;
  logic          run_open;
  logic [CW-1:0] term_cnt;
  logic [WW-1:0] wait_cnt;
  logic [OW-1:0] acc;

  logic          accept;
  logic          eff_mode;
  logic [OW-1:0] sop_add;

  assign ready    = (state == IDLE) && !reset;
  assign accept   = valid_input && ready;
  // An open sum-of-products run pins the mode until it closes.
  assign eff_mode = run_open ? mode_q : mode;
  assign sop_add  = run_open ? acc : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      c_q          <= '0;
      last_q       <= 1'b0;
      mode_q       <= 1'b0;
      pass2        <= 1'b0;
      run_open     <= 1'b0;
      term_cnt     <= '0;
      wait_cnt     <= '0;
      acc          <= '0;
      mac_start    <= 1'b0;
      mac_in_1     <= '0;
      mac_in_2     <= '0;
      mac_in_add   <= '0;
      valid_output <= 1'b0;
      final_output <= '0;
      forced_last  <= 1'b0;
    end else begin
      mac_start    <= 1'b0;
      valid_output <= 1'b0;
      forced_last  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            c_q       <= num_c;
            last_q    <= last_input;
            mode_q    <= eff_mode;
            pass2     <= 1'b0;
            mac_start <= 1'b1;
            mac_in_1  <= OW'(num_a);
            mac_in_2  <= num_x;
            if (eff_mode) begin
              mac_in_add <= OW'(num_b);
            end else begin
              mac_in_add <= sop_add;
              if (!run_open) begin
                run_open <= 1'b1;
                term_cnt <= CW'(1);
              end
            end
            state <= ISSUE;
          end
        end
        ISSUE: begin
          wait_cnt <= WAIT_INIT;
          state    <= WAIT;
        end
        WAIT: begin
          if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - WW'(1);
          end else begin
            acc <= mac_out;
            if (mode_q && !pass2) begin
              // Second trinomial pass reuses x; the first pass result is the multiplicand.
              pass2      <= 1'b1;
              mac_start  <= 1'b1;
              mac_in_1   <= mac_out;
              mac_in_add <= OW'(c_q);
              state      <= ISSUE;
            end else begin
              mac_in_1   <= '0;
              mac_in_2   <= '0;
              mac_in_add <= '0;
              if (mode_q || last_q || (term_cnt == MAX_CNT)) begin
                valid_output <= 1'b1;
                final_output <= mac_out;
                forced_last  <= !mode_q && !last_q;
                state        <= OUT;
              end else begin
                term_cnt <= term_cnt + CW'(1);
                state    <= IDLE;
              end
            end
          end
        end
        OUT: begin
          run_open <= 1'b0;
          term_cnt <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mac_sequencer.sv
`default_nettype none
// tb_mac_sequencer: directed and random operand sets checked every cycle
// against a transaction-level model of the sequencer.
module tb_mac_sequencer;

  localparam int     DW        = 8;
  localparam int     OW        = 17;
  localparam int     MAC_LAT   = 1;
  localparam int     MAX_TERMS = 4;
  localparam longint MOD       = longint'(1) << OW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          mode = 1'b0;
  logic          valid_input = 1'b0;
  logic          last_input = 1'b0;
  logic [DW-1:0] num_a = '0, num_b = '0, num_c = '0, num_x = '0;
  logic          ready, mac_start, valid_output, forced_last;
  logic [OW-1:0] mac_in_1, mac_in_add, mac_out, final_output;
  logic [DW-1:0] mac_in_2;

  mac_sequencer #(.DW(DW), .OW(OW), .MAC_LAT(MAC_LAT), .MAX_TERMS(MAX_TERMS)) dut (
    .clk(clk), .reset(reset), .mode(mode), .valid_input(valid_input),
    .last_input(last_input), .num_a(num_a), .num_b(num_b), .num_c(num_c),
    .num_x(num_x), .ready(ready), .mac_start(mac_start), .mac_in_1(mac_in_1),
    .mac_in_2(mac_in_2), .mac_in_add(mac_in_add), .mac_out(mac_out),
    .valid_output(valid_output), .final_output(final_output),
    .forced_last(forced_last)
  );

  always #5 clk = ~clk;

  // External multiply-add unit with MAC_LAT cycles of latency.
  logic [OW+DW-1:0] mac_full;
  logic [OW-1:0]    mac_pipe [MAC_LAT];
  assign mac_full = (OW+DW)'(mac_in_1) * (OW+DW)'(mac_in_2) + (OW+DW)'(mac_in_add);
  always @(posedge clk) begin
    mac_pipe[0] <= mac_full[OW-1:0];
    for (int i = 1; i < MAC_LAT; i++) mac_pipe[i] <= mac_pipe[i-1];
  end
  assign mac_out = mac_pipe[MAC_LAT-1];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction-level model: expected issues and results keyed by cycle.
  typedef struct packed {logic [OW-1:0] in1; logic [DW-1:0] in2; logic [OW-1:0] add;} issue_t;
  typedef struct packed {logic [OW-1:0] val; logic forced;} result_t;
  issue_t        exp_issue [int];
  result_t       exp_res   [int];
  int            busy_until = 0;
  bit            m_open = 0, m_mode = 0;
  longint        m_sum = 0;
  int            m_cnt = 0;
  logic [OW-1:0] m_final = '0;
  int            acc_cyc[$], obs_cyc[$], obs_scyc[$];
  longint        obs_val[$], obs_add[$];
  bit            obs_forced[$];

  task automatic model_accept(input int c);
    longint p1, r, add;
    acc_cyc.push_back(c);
    if (!m_open) m_mode = mode;
    if (m_mode) begin
      p1 = (longint'(num_a) * num_x + num_b) % MOD;
      r  = (p1 * num_x + num_c) % MOD;
      exp_issue[c+1]         = {OW'(num_a), num_x, OW'(num_b)};
      exp_issue[c+MAC_LAT+2] = {OW'(p1), num_x, OW'(num_c)};
      exp_res[c+2*MAC_LAT+3] = {OW'(r), 1'b0};
      busy_until = c + 2*MAC_LAT + 3;
    end else begin
      add    = m_open ? m_sum : 0;
      m_sum  = (add + longint'(num_a) * num_x) % MOD;
      m_cnt  = m_open ? m_cnt + 1 : 1;
      m_open = 1;
      exp_issue[c+1] = {OW'(num_a), num_x, OW'(add)};
      if (last_input || m_cnt == MAX_TERMS) begin
        exp_res[c+MAC_LAT+2] = {OW'(m_sum), !last_input};
        m_open     = 0;
        busy_until = c + MAC_LAT + 2;
      end else begin
        busy_until = c + MAC_LAT + 1;
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      exp_issue.delete();
      exp_res.delete();
      m_open = 0; m_sum = 0; m_cnt = 0; m_final = '0; busy_until = 0;
      chk("ready_in_reset", ready, 0);
      chk("valid_in_reset", valid_output, 0);
      chk("start_in_reset", mac_start, 0);
      chk("final_in_reset", final_output, 0);
    end else begin
      chk("ready", ready, cyc > busy_until);
      if (exp_res.exists(cyc)) begin
        m_final = exp_res[cyc].val;
        chk("valid_output", valid_output, 1);
        chk("forced_last", forced_last, exp_res[cyc].forced);
        exp_res.delete(cyc);
      end else begin
        chk("valid_output", valid_output, 0);
        chk("forced_last", forced_last, 0);
      end
      chk("final_output", final_output, m_final);
      if (exp_issue.exists(cyc)) begin
        chk("mac_start", mac_start, 1);
        chk("mac_in_1", mac_in_1, exp_issue[cyc].in1);
        chk("mac_in_2", mac_in_2, exp_issue[cyc].in2);
        chk("mac_in_add", mac_in_add, exp_issue[cyc].add);
        exp_issue.delete(cyc);
      end else begin
        chk("mac_start", mac_start, 0);
      end
      if (valid_output) begin
        obs_val.push_back(final_output);
        obs_cyc.push_back(cyc);
        obs_forced.push_back(forced_last);
      end
      if (mac_start) begin
        obs_add.push_back(mac_in_add);
        obs_scyc.push_back(cyc);
      end
      if (valid_input && ready) model_accept(cyc);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    acc_cyc.delete(); obs_cyc.delete(); obs_scyc.delete();
    obs_val.delete(); obs_add.delete(); obs_forced.delete();
  endtask

  // Present an operand set and hold it until accepted; drop toggles valid while waiting.
  task automatic send(input bit m, input int a, input int x, input int b, input int c,
                      input bit last, input bit keep, input bit drop);
    mode = m; num_a = DW'(a); num_x = DW'(x); num_b = DW'(b); num_c = DW'(c);
    last_input  = last;
    valid_input = drop ? 1'($urandom_range(0, 1)) : 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (ready && valid_input) begin
        @(posedge clk); #1;
        if (!keep) valid_input = 1'b0;
        return;
      end
      @(posedge clk); #1;
      valid_input = drop ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
    chk("accept_timeout", 0, 1);
    valid_input = 1'b0;
  endtask

  initial begin
    #200000;
    chk("watchdog", 0, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    tick(3);
    chk("reset_ready", ready, 0);
    chk("reset_final", final_output, 0);
    reset = 1'b0;
    tick(2);
    chk("ready_after_reset", ready, 1);

    // Trinomial basic: (5*3+2)*3+1 = 52
    clear_obs();
    send(1, 5, 3, 2, 1, 0, 0, 0);
    tick(8);
    chk("tri_count", obs_val.size(), 1);
    if (obs_val.size() == 1 && obs_scyc.size() == 2) begin
      chk("tri_value", obs_val[0], 52);
      chk("tri_latency", obs_cyc[0] - acc_cyc[0], 5);
      chk("tri_start1", obs_scyc[0] - acc_cyc[0], 1);
      chk("tri_start2", obs_scyc[1] - acc_cyc[0], 3);
      chk("tri_forced", obs_forced[0], 0);
    end
    chk("tri_hold", final_output, 52);

    // Back-to-back with valid held: (9*8+7)*8+6 = 638, then random
    clear_obs();
    send(1, 9, 8, 7, 6, 0, 1, 0);
    send(1, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
         $urandom_range(0, 255), 0, 0, 0);
    tick(14);
    chk("b2b_count", obs_val.size(), 2);
    if (obs_val.size() == 2 && acc_cyc.size() == 2) begin
      chk("b2b_first", obs_val[0], 638);
      chk("b2b_gap", acc_cyc[1] - acc_cyc[0], 6);
    end

    // Wrap-around: 16646655 mod 2^17 = 511
    clear_obs();
    send(1, 255, 255, 255, 255, 0, 0, 0);
    tick(8);
    chk("wrap_count", obs_val.size(), 1);
    if (obs_val.size() == 1) chk("wrap_value", obs_val[0], 511);

    // Sum of products 5*3 + 9*8 + 2*4 = 95, gaps, dropouts and a mode toggle
    clear_obs();
    send(0, 5, 3, $urandom_range(0, 255), $urandom_range(0, 255), 0, 0, 1);
    tick(3);
    send(1, 9, 8, $urandom_range(0, 255), $urandom_range(0, 255), 0, 0, 1);
    tick(2);
    send(0, 2, 4, $urandom_range(0, 255), $urandom_range(0, 255), 1, 0, 1);
    tick(6);
    chk("sop_count", obs_val.size(), 1);
    if (obs_val.size() == 1 && obs_add.size() == 3) begin
      chk("sop_value", obs_val[0], 95);
      chk("sop_forced", obs_forced[0], 0);
      chk("sop_add0", obs_add[0], 0);
      chk("sop_add1", obs_add[1], 15);
      chk("sop_add2", obs_add[2], 87);
    end

    // MAX_TERMS close, then a fresh run closed normally
    clear_obs();
    for (int i = 0; i < 5; i++) send(0, 1, 1, 0, 0, 0, 0, 0);
    send(0, 1, 1, 0, 0, 1, 0, 0);
    tick(6);
    chk("max_count", obs_val.size(), 2);
    if (obs_val.size() == 2 && obs_add.size() == 6) begin
      chk("max_value", obs_val[0], 4);
      chk("max_forced", obs_forced[0], 1);
      chk("max_add4", obs_add[3], 3);
      chk("max_add5", obs_add[4], 0);
      chk("next_value", obs_val[1], 2);
      chk("next_forced", obs_forced[1], 0);
    end

    // Reset during pass 2 of a trinomial
    clear_obs();
    send(1, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
         $urandom_range(0, 255), 0, 0, 0);
    tick(2);
    reset = 1'b1;
    tick(1);
    @(negedge clk);
    chk("rst_ready", ready, 0);
    chk("rst_valid", valid_output, 0);
    chk("rst_in1", mac_in_1, 0);
    chk("rst_final", final_output, 0);
    tick(1);
    reset = 1'b0;
    tick(12);
    chk("rst_no_result", obs_val.size(), 0);
    send(1, 5, 3, 2, 1, 0, 0, 0);
    tick(8);
    chk("rst_next_count", obs_val.size(), 1);
    if (obs_val.size() == 1) chk("rst_next_value", obs_val[0], 52);

    // Random mixed traffic
    for (int i = 0; i < 60; i++) begin
      send(1'($urandom_range(0, 1)), $urandom_range(0, 255), $urandom_range(0, 255),
           $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 3) == 0,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        valid_input = 1'b0;
        tick($urandom_range(1, 3));
      end
    end
    send(0, $urandom_range(0, 255), $urandom_range(0, 255), 0, 0, 1, 0, 0);
    valid_input = 1'b0;
    tick(12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
